usr_shift_unit: RTL and testbench
=================================

# usr_shift_unit

Parametrised universal shift unit, the successor to the team's 2-bit-control universal shift register. Adds multi-bit logical, arithmetic and rotate shifts by a runtime amount, and a self-sequenced serial burst mode with busy/done handshake. Used as a general-purpose shift/serialiser element in datapaths and as the serialiser front end for simple bit-serial links.

## Interface
- N, default 8: register width. Legal range is N ≥ 2.
- AW, default $clog2(N): width of the shift-amount port. Derived; never overridden.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  reset, asynchronous, active-high.
- en  input  1  operation enable; sampled only in IDLE.
- op  input  3  operation code (see Operation).
- amt  input  AW  shift amount, or burst length.
- sin  input  1  serial fill bit for SHL, SHR and BURST.
- d  input  N  parallel load data.
- q  output  N  register contents.
- sout  output  1  serial out, equal to q[N-1] (combinational from the register).
- busy  output  1  high while a burst is running.
- done  output  1  single-cycle pulse marking burst completion.

## Operation
- Op codes:
  - 0 HOLD.
  - 1 SHL: q <= q << amt; vacated LSBs filled with sin.
  - 2 SHR: q <= q >> amt; vacated MSBs filled with sin.
  - 3 LOAD: q <= d.
  - 4 ROL: rotate left by amt.
  - 5 ROR: rotate right by amt.
  - 6 ASR: arithmetic shift right by amt; vacated bits filled with the old q[N-1].
  - 7 BURST: start a serial burst.
- amt = 0 on any shift or rotate leaves q unchanged.
- amt ≥ N (possible only when N is not a power of two):
  - SHL and SHR produce all-sin.
  - ASR produces all copies of the sign bit.
  - ROL and ROR rotate by amt mod N.
- FSM states: IDLE and RUN.
- IDLE with en = 0: hold everything; op and amt are ignored.
- IDLE with en = 1 and op 0–6: execute the op at the edge; stay in IDLE.
- IDLE with en = 1, op = BURST and amt ≠ 0:
  - At the edge, load the internal counter cnt with amt, enter RUN, busy = 1.
  - q is not modified on the start edge.
- IDLE with en = 1, op = BURST and amt = 0: stay in IDLE, q unchanged, done pulses in the next cycle.
- RUN, every edge:
  - q <= {q[N-2:0], sin}; cnt decrements.
  - en and op are ignored.
  - When cnt = 1 at the edge, return to IDLE: busy falls and done = 1 for exactly that one cycle.
- Burst result: a burst of length K shifts exactly K bits out through sout, MSB first. Each bit is visible on sout before the edge that discards it.
- Reset at any time, including mid-burst:
  - q = 0, cnt = 0, state IDLE, busy = 0, done = 0.
  - The burst is aborted and no done pulse is produced.

## Timing
- Ops 0–6 have 1-cycle latency: the result is on q after the sampling edge.
- BURST of length K ≥ 1:
  - Start edge E0.
  - Shifts occur at edges E1..EK.
  - busy is high from after E0 until EK.
  - done is high for the one cycle after EK.
- A new command is accepted in the same cycle done is high. This gives back-to-back bursts with 1 idle-sampling cycle between them.
- All outputs are registered or derived combinationally from registers only; there are no input-to-output combinational paths.

## Configuration
- USR_ROTATE_EN defined: ROL and ROR are implemented as described above.
- USR_ROTATE_EN undefined: op codes 4 and 5 behave as HOLD, and the rotate datapath is not synthesised. All other ops are unaffected.

## Structure
- Package usr_pkg contains:
  - the enum usr_op_e (3-bit op codes above);
  - the enum usr_state_e (IDLE, RUN).
- Sub-module usr_barrel_shifter: a purely combinational N-bit shifter taking q, amt, sin and the op. It returns the next value for ops 1, 2, 4, 5 and 6; its rotate logic is under USR_ROTATE_EN.
- The top module holds q, the FSM, cnt (width AW), the done register and the op decode.

## Test plan
All scenarios use N = 8.
- Reset, then LOAD d = 8'hA5 → q = 8'hA5, busy = 0, done = 0; assert reset mid-cycle → q = 0 immediately.
- q = 8'hA5:
  - SHL amt = 3, sin = 1 → q = 8'h2F.
  - Then SHR amt = 2, sin = 0 → q = 8'h0B.
- q = 8'h96, ASR amt = 3 → q = 8'hF2. With USR_ROTATE_EN defined: q = 8'h96, ROL amt = 3 → q = 8'hB4.
- USR_ROTATE_EN undefined: q = 8'h96, ROR amt = 1 → q stays 8'h96.
- q = 8'hC3, BURST amt = 4, sin = 0:
  - busy is high for 4 cycles.
  - sout sequence is 1, 1, 0, 0.
  - Final q = 8'h30 with done pulsing for 1 cycle.
  - op toggled during RUN has no effect.
- Start BURST amt = 5, assert reset after 2 shifts → q = 0, busy = 0, no done pulse. Then BURST amt = 0 → done pulses next cycle, q unchanged.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared types for the universal shift unit: operation codes and FSM states.
// The rotate ops are only live when the design is built with USR_ROTATE_EN.
package usr_pkg;

    typedef enum logic [2:0] {
        OP_HOLD  = 3'd0,
        OP_SHL   = 3'd1,
        OP_SHR   = 3'd2,
        OP_LOAD  = 3'd3,
        OP_ROL   = 3'd4,
        OP_ROR   = 3'd5,
        OP_ASR   = 3'd6,
        OP_BURST = 3'd7
    } usr_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } usr_state_e;

endpackage

// File: rtl/usr_barrel_shifter.sv
// Combinational N-bit shifter producing the next register value for SHL/SHR/ASR,
// plus ROL/ROR when USR_ROTATE_EN is defined (otherwise rotates return q unchanged).
module usr_barrel_shifter
    import usr_pkg::*;
#(
    parameter  int N  = 8,
    localparam int AW = $clog2(N)
) (
    input  logic [N-1:0]  q,
    input  logic [AW-1:0] amt,
    input  logic          sin,
    input  usr_op_e       op,
    output logic [N-1:0]  res
);

    logic [2*N-1:0] wide;
    int unsigned    amt_i;
`ifdef USR_ROTATE_EN
    int unsigned    rot;
`endif

    // Fill bits are concatenated above/below q so a single shift brings them in.
    always_comb begin
        res   = q;
        wide  = '0;
        amt_i = 32'(amt);
`ifdef USR_ROTATE_EN
        rot   = amt_i % N;
`endif
        case (op)
            OP_SHL: begin
                wide = {q, {N{sin}}} << amt_i;
                res  = (amt_i >= N) ? {N{sin}} : wide[2*N-1:N];
            end
            OP_SHR: begin
                wide = {{N{sin}}, q} >> amt_i;
                res  = (amt_i >= N) ? {N{sin}} : wide[N-1:0];
            end
            OP_ASR: begin
                wide = {{N{q[N-1]}}, q} >> amt_i;
                res  = (amt_i >= N) ? {N{q[N-1]}} : wide[N-1:0];
            end
`ifdef USR_ROTATE_EN
            OP_ROL: begin
                wide = {q, q} << rot;
                res  = wide[2*N-1:N];
            end
            OP_ROR: begin
                wide = {q, q} >> rot;
                res  = wide[N-1:0];
            end
`endif
            default: res = q;
        endcase
    end

endmodule

// File: rtl/usr_shift_unit.sv
// Universal shift unit: single-cycle shift/rotate/load ops and a self-sequenced
// serial burst with busy/done. Rotates are built only with USR_ROTATE_EN defined.
module usr_shift_unit
    import usr_pkg::*;
#(
    parameter  int N  = 8,
    localparam int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [2:0]    op,
    input  logic [AW-1:0] amt,
    input  logic          sin,
    input  logic [N-1:0]  d,
    output logic [N-1:0]  q,
    output logic          sout,
    output logic          busy,
    output logic          done
);

    usr_state_e    state, state_nxt;
    usr_op_e       op_e;
    logic [N-1:0]  q_nxt;
    logic [N-1:0]  shifted;
    logic [AW-1:0] cnt, cnt_nxt;
    logic          done_nxt;

    assign op_e = usr_op_e'(op);
    assign sout = q[N-1];
    assign busy = (state == ST_RUN);

    usr_barrel_shifter #(.N(N)) u_shifter (
        .q   (q),
        .amt (amt),
        .sin (sin),
        .op  (op_e),
        .res (shifted)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            q     <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            q     <= q_nxt;
            cnt   <= cnt_nxt;
            done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        q_nxt     = q;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en) begin
                    case (op_e)
                        OP_HOLD: q_nxt = q;
                        OP_LOAD: q_nxt = d;
                        OP_BURST: begin
                            // A zero-length burst completes immediately without touching q.
                            if (amt != '0) begin
                                cnt_nxt   = amt;
                                state_nxt = ST_RUN;
                            end else begin
                                done_nxt = 1'b1;
                            end
                        end
                        default: q_nxt = shifted;
                    endcase
                end
            end
            ST_RUN: begin
                q_nxt   = {q[N-2:0], sin};
                cnt_nxt = cnt - AW'(1);
                if (cnt == AW'(1)) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_usr_shift_unit.sv
// Self-checking bench for usr_shift_unit (N = 8); rotate checks follow USR_ROTATE_EN.
module tb_usr_shift_unit;

    localparam int N  = 8;
    localparam int AW = $clog2(N);

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          en    = 1'b0;
    logic [2:0]    op    = '0;
    logic [AW-1:0] amt   = '0;
    logic          sin   = 1'b0;
    logic [N-1:0]  d     = '0;
    logic [N-1:0]  q;
    logic          sout;
    logic          busy;
    logic          done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string        tag;
        logic [N-1:0] exp;
    } exp_t;

    exp_t         sb[$];
    exp_t         e;
    logic [N-1:0] mq;

    usr_shift_unit #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .op    (op),
        .amt   (amt),
        .sin   (sin),
        .d     (d),
        .q     (q),
        .sout  (sout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit-by-bit reference for ops 0-6 (load handled by the caller).
    function automatic logic [N-1:0] model(input logic [2:0] o, input logic [N-1:0] cur,
                                           input int a, input logic s);
        logic [N-1:0] r;
        r = cur;
        for (int i = 0; i < N; i++) begin
            case (o)
                3'd1: r[i] = (i - a >= 0) ? cur[i - a] : s;
                3'd2: r[i] = (i + a < N) ? cur[i + a] : s;
                3'd6: r[i] = (i + a < N) ? cur[i + a] : cur[N-1];
`ifdef USR_ROTATE_EN
                3'd4: r[i] = cur[(i - (a % N) + N) % N];
                3'd5: r[i] = cur[(i + a) % N];
`endif
                default: r[i] = cur[i];
            endcase
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_check();
        if (sb.size() == 0) begin
            check_val("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check_val(e.tag, 32'(q), 32'(e.exp));
        end
    endtask

    task automatic issue(input logic [2:0] o, input int a, input logic s,
                         input logic [N-1:0] dd, input string tag);
        en  = 1'b1;
        op  = o;
        amt = AW'(a);
        sin = s;
        d   = dd;
        mq  = (o == 3'd3) ? dd : model(o, mq, a, s);
        sb.push_back('{tag, mq});
        step();
        en = 1'b0;
        sb_check();
    endtask

    initial begin
        mq = '0;
        step();
        step();
        check_val("rst_q", 32'(q), 32'h0);
        check_val("rst_busy", 32'(busy), 32'h0);
        check_val("rst_done", 32'(done), 32'h0);
        reset = 1'b0;
        step();

        issue(3'd3, 0, 1'b0, 8'hA5, "load_a5");
        check_val("load_busy", 32'(busy), 32'h0);
        check_val("load_done", 32'(done), 32'h0);
        #2 reset = 1'b1;
        #1 check_val("async_rst_q", 32'(q), 32'h0);
        mq = '0;
        step();
        reset = 1'b0;

        issue(3'd3, 0, 1'b0, 8'hA5, "load_a5b");
        issue(3'd1, 3, 1'b1, '0, "shl3");
        check_val("shl3_const", 32'(q), 32'h2F);
        issue(3'd2, 2, 1'b0, '0, "shr2");
        check_val("shr2_const", 32'(q), 32'h0B);
        issue(3'd3, 0, 1'b0, 8'h96, "load_96");
        issue(3'd6, 3, 1'b0, '0, "asr3");
        check_val("asr3_const", 32'(q), 32'hF2);
        issue(3'd3, 0, 1'b0, 8'h96, "load_96b");
`ifdef USR_ROTATE_EN
        issue(3'd4, 3, 1'b0, '0, "rol3");
        check_val("rol3_const", 32'(q), 32'hB4);
`else
        issue(3'd5, 1, 1'b0, '0, "ror1_hold");
        check_val("ror1_const", 32'(q), 32'h96);
`endif
        issue(3'd0, 5, 1'b1, 8'hFF, "hold");
        en = 1'b0; op = 3'd3; d = 8'h11;
        step();
        check_val("en0_hold", 32'(q), 32'(mq));

        for (int i = 0; i < 40; i++) begin
            issue(3'($urandom_range(0, 6)), int'($urandom_range(0, 7)), 1'($urandom),
                  8'($urandom), "rand_op");
            check_val("rand_busy", 32'(busy), 32'h0);
        end

        // Burst of 4 from C3, op/en scrambled while running.
        issue(3'd3, 0, 1'b0, 8'hC3, "load_c3");
        en = 1'b1; op = 3'd7; amt = AW'(4); sin = 1'b0;
        check_val("b4_sout0", 32'(sout), 32'(mq[N-1]));
        step();
        check_val("b4_start_busy", 32'(busy), 32'h1);
        check_val("b4_start_q", 32'(q), 32'hC3);
        for (int k = 0; k < 4; k++) begin
            en = 1'($urandom);
            op = 3'($urandom);
            check_val("b4_busy", 32'(busy), 32'h1);
            check_val("b4_done_low", 32'(done), 32'h0);
            check_val("b4_sout", 32'(sout), 32'(mq[N-1]));
            mq = {mq[N-2:0], 1'b0};
            sb.push_back('{"b4_shift", mq});
            step();
            sb_check();
        end
        check_val("b4_busy_end", 32'(busy), 32'h0);
        check_val("b4_done", 32'(done), 32'h1);
        check_val("b4_q_const", 32'(q), 32'h30);

        // Back-to-back burst accepted in the done cycle.
        en = 1'b1; op = 3'd7; amt = AW'(2); sin = 1'b1;
        step();
        en = 1'b0;
        check_val("b2_busy", 32'(busy), 32'h1);
        check_val("b2_done_low", 32'(done), 32'h0);
        for (int k = 0; k < 2; k++) begin
            mq = {mq[N-2:0], 1'b1};
            sb.push_back('{"b2_shift", mq});
            step();
            sb_check();
        end
        check_val("b2_done", 32'(done), 32'h1);
        check_val("b2_q_const", 32'(q), 32'hC3);
        step();
        check_val("b2_done_fall", 32'(done), 32'h0);

        // Burst aborted by reset after two shifts.
        issue(3'd3, 0, 1'b0, 8'h5A, "load_5a");
        en = 1'b1; op = 3'd7; amt = AW'(5); sin = 1'b1;
        step();
        en = 1'b0;
        step();
        step();
        check_val("abort_busy_pre", 32'(busy), 32'h1);
        #2 reset = 1'b1;
        #1;
        check_val("abort_q", 32'(q), 32'h0);
        check_val("abort_busy", 32'(busy), 32'h0);
        check_val("abort_done", 32'(done), 32'h0);
        mq = '0;
        step();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check_val("abort_no_done", 32'(done), 32'h0);
            check_val("abort_idle", 32'(busy), 32'h0);
        end

        // Zero-length burst.
        issue(3'd3, 0, 1'b0, 8'h3C, "load_3c");
        en = 1'b1; op = 3'd7; amt = '0;
        step();
        en = 1'b0;
        check_val("b0_done", 32'(done), 32'h1);
        check_val("b0_busy", 32'(busy), 32'h0);
        check_val("b0_q", 32'(q), 32'h3C);
        step();
        check_val("b0_done_fall", 32'(done), 32'h0);

        check_val("sb_drained", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
